// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop/pause and a one-clk done pulse on expiry.
// Optional COUNTDOWN_AUTO_RELOAD_EN: terminal tick reloads the latched interval and keeps running.
module countdown_timer #(
    parameter int bitSize      = 8,
    parameter int prescaleBits = 4,
    parameter int prescaleDiv  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bitSize-1:0] load_val,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    output logic [bitSize-1:0] count,
    output logic               busy,
    output logic               done,
    output logic               expired
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam logic [prescaleBits-1:0] PS_LAST = prescaleBits'(prescaleDiv - 1);

    state_t                  state, state_nxt;
    logic [bitSize-1:0]      count_nxt;
    logic [bitSize-1:0]      load_q, load_nxt;
    logic [prescaleBits-1:0] presc, presc_nxt;
    logic                    done_nxt;
    logic                    tick;

    assign tick    = (presc == PS_LAST);
    assign busy    = (state == RUN) || (state == PAUSE);
    assign expired = (state == EXPIRED);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        presc_nxt = presc;
        load_nxt  = load_q;
        done_nxt  = 1'b0;

        if (stop) begin
            state_nxt = IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else if (start) begin
            load_nxt  = load_val;
            presc_nxt = '0;
            count_nxt = load_val;
            if (load_val == '0) begin
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            case (state)
                RUN, PAUSE: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else begin
                        // Leaving PAUSE counts as a running cycle so a k-cycle pause delays done by k.
                        state_nxt = RUN;
                        if (tick) begin
                            presc_nxt = '0;
                            if (count <= bitSize'(1)) begin
                                done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                count_nxt = load_q;
`else
                                count_nxt = '0;
                                state_nxt = EXPIRED;
`endif
                            end else begin
                                count_nxt = count - bitSize'(1);
                            end
                        end else begin
                            presc_nxt = presc + prescaleBits'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            presc  <= '0;
            load_q <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            presc  <= presc_nxt;
            load_q <= load_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and random stimulus on two timers (prescale 1 and 4) against an elapsed-cycle model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] load_val = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;

    logic [7:0] count1, count4;
    logic       busy1, busy4, done1, done4, exp1, exp4;

    int errors = 0;
    int checks = 0;

    // Model: per timer, mode (0 idle, 1 active, 2 expired), interval n, running cycles since (re)load.
    int m_mode[2];
    int m_n[2];
    int m_runc[2];
    bit m_done[2];
    int m_div[2] = '{1, 4};

    always #5 clk = ~clk;

    countdown_timer #(.bitSize(8), .prescaleBits(4), .prescaleDiv(1)) u_dut1 (
        .clk(clk), .reset(reset), .load_val(load_val), .start(start), .stop(stop), .pause(pause),
        .count(count1), .busy(busy1), .done(done1), .expired(exp1)
    );

    countdown_timer #(.bitSize(8), .prescaleBits(4), .prescaleDiv(4)) u_dut4 (
        .clk(clk), .reset(reset), .load_val(load_val), .start(start), .stop(stop), .pause(pause),
        .count(count4), .busy(busy4), .done(done4), .expired(exp4)
    );

    function automatic int exp_count(int m);
        if (m_mode[m] != 1) return 0;
        return m_n[m] - m_runc[m] / m_div[m];
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_step(input int m, input logic r, sp, st, pa, input logic [7:0] ld);
        m_done[m] = 1'b0;
        if (r) begin
            m_mode[m] = 0; m_n[m] = 0; m_runc[m] = 0;
        end else if (sp) begin
            m_mode[m] = 0; m_runc[m] = 0;
        end else if (st) begin
            m_n[m] = int'(ld);
            m_runc[m] = 0;
            if (ld == 8'd0) begin
                m_mode[m] = 2; m_done[m] = 1'b1;
            end else begin
                m_mode[m] = 1;
            end
        end else if (m_mode[m] == 1 && !pa) begin
            m_runc[m]++;
            if (m_runc[m] == m_n[m] * m_div[m]) begin
                m_done[m] = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                m_runc[m] = 0;
`else
                m_mode[m] = 2;
`endif
            end
        end
    endtask

    task automatic cyc(input logic r, sp, st, pa, input logic [7:0] ld);
        reset = r; stop = sp; start = st; pause = pa; load_val = ld;
        @(posedge clk);
        model_step(0, r, sp, st, pa, ld);
        model_step(1, r, sp, st, pa, ld);
        #1;
        chk("count_div1",   int'(count1), exp_count(0));
        chk("busy_div1",    int'(busy1),  int'(m_mode[0] == 1));
        chk("done_div1",    int'(done1),  int'(m_done[0]));
        chk("expired_div1", int'(exp1),   int'(m_mode[0] == 2));
        chk("count_div4",   int'(count4), exp_count(1));
        chk("busy_div4",    int'(busy4),  int'(m_mode[1] == 1));
        chk("done_div4",    int'(done4),  int'(m_done[1]));
        chk("expired_div4", int'(exp4),   int'(m_mode[1] == 2));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'd0);
    endtask

    initial begin
        int first;
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = 0; m_n[m] = 0; m_runc[m] = 0; m_done[m] = 1'b0;
        end

        // Reset state
        cyc(1, 0, 0, 0, 8'd0);
        cyc(1, 0, 0, 0, 8'd0);
        chk("reset_count", int'(count1), 0);

        // Five-count run at prescale 1
        cyc(0, 0, 1, 0, 8'd5);
        chk("t1_load", int'(count1), 5);
        idle(4);
        chk("t1_last", int'(count1), 1);
        idle(1);
        chk("t1_done", int'(done1), 1);
        idle(3);

        // Prescale 4: done 12 clks after the start edge
        cyc(0, 0, 1, 0, 8'd3);
        first = 0;
        for (int i = 1; i <= 14; i++) begin
            idle(1);
            if (done4 && first == 0) first = i;
        end
        chk("t2_latency_div4", first, 12);

        // Pause for 7 clks at count 6 delays done by 7
        cyc(0, 0, 1, 0, 8'd10);
        idle(4);
        chk("t3_at6", int'(count1), 6);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 8'd0);
        chk("t3_hold", int'(count1), 6);
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            if (done1 && first == 0) first = 4 + 7 + i;
        end
        chk("t3_latency", first, 17);
        idle(30);

        // Stop and start colliding with the terminal tick
        cyc(0, 0, 1, 0, 8'd4);
        idle(3);
        cyc(0, 1, 0, 0, 8'd0);
        chk("t4_stop_cnt", int'(count1), 0);
        chk("t4_stop_done", int'(done1), 0);
        cyc(0, 0, 1, 0, 8'd4);
        idle(3);
        cyc(0, 0, 1, 0, 8'd2);
        chk("t4_restart", int'(count1), 2);
        idle(4);
        // Pause on the terminal tick keeps count at 1
        cyc(0, 0, 1, 0, 8'd2);
        idle(1);
        cyc(0, 0, 0, 1, 8'd0);
        chk("t4_pause_term", int'(count1), 1);
        idle(2);

        // Zero load, then reset mid-run
        cyc(0, 0, 1, 0, 8'd0);
        chk("t5_zero_done", int'(done1), 1);
        idle(1);
        cyc(0, 0, 1, 0, 8'd8);
        idle(3);
        cyc(1, 0, 0, 0, 8'd0);
        chk("t5_reset_busy", int'(busy1), 0);

        // Repeated periods (reload in auto-reload builds), then stop
        cyc(0, 0, 0, 0, 8'd0);
        cyc(0, 0, 1, 0, 8'd3);
        idle(13);
        cyc(0, 1, 0, 0, 8'd0);

        // Full-scale interval
        cyc(0, 0, 1, 0, 8'hFF);
        idle(260);

        // Random control traffic
        for (int i = 0; i < 4000; i++) begin
            logic r, sp, st, pa;
            logic [7:0] ld;
            r  = ($urandom_range(199) == 0);
            sp = ($urandom_range(59) == 0);
            st = ($urandom_range(29) == 0);
            pa = ($urandom_range(3) == 0);
            case ($urandom_range(9))
                0:       ld = 8'd0;
                1:       ld = 8'hFF;
                default: ld = 8'($urandom_range(1, 12));
            endcase
            cyc(r, sp, st, pa, ld);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
